// File: rtl/apb_pkg.sv
// Shared types and address-map constants for the core-to-APB bridge.
// Also used by the core glue and the bus fabric, so keep the map here only.
package apb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, MISS} apb_state_e;

    localparam int          DEF_NUM_SLV   = 4;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
    localparam int          DEF_SLV_AW    = 12;

    // Peripheral address map: one 4 KiB slot per APB slave.
    localparam logic [31:0] UART_BASE  = 32'h1000_0000;
    localparam logic [31:0] TIMER_BASE = 32'h1000_1000;
    localparam logic [31:0] GPIO_BASE  = 32'h1000_2000;
    localparam logic [31:0] SPI_BASE   = 32'h1000_3000;

    function automatic logic [31:0] slot_base(input int unsigned idx);
        return DEF_BASE_ADDR + (32'(idx) << DEF_SLV_AW);
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// APB (AMBA3) bus bundle between the bridge and the peripheral fabric.
// PRDATA/PREADY are per-slot; the fabric does not mux them.
interface apb_master_if #(
    parameter int NUM_SLV = 4
);
    logic [31:0]              PADDR;
    logic [31:0]              PWDATA;
    logic                     PWRITE;
    logic                     PENABLE;
    logic [NUM_SLV-1:0]       PSEL;
    logic [NUM_SLV-1:0][31:0] PRDATA;
    logic [NUM_SLV-1:0]       PREADY;

    modport master (
        output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_addr_decoder.sv
// Combinational peripheral-window decoder: one-hot slot select plus hit flag.
// Shared with the AXI4-Lite bridge; needs NUM_SLV >= 2.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int          NUM_SLV   = DEF_NUM_SLV,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          SLV_AW    = DEF_SLV_AW
) (
    input  logic [31:0]        addr,
    output logic [NUM_SLV-1:0] sel,
    output logic               hit
);
    localparam int IDX_W   = $clog2(NUM_SLV);
    localparam int TOP_LSB = SLV_AW + IDX_W;

    logic [IDX_W-1:0] idx;
    logic             in_window;
    logic             unused_offset;

    assign unused_offset = ^addr[SLV_AW-1:0];

    // The index range check only matters when NUM_SLV is not a power of two.
    always_comb begin
        idx       = addr[TOP_LSB-1:SLV_AW];
        in_window = (addr[31:TOP_LSB] == BASE_ADDR[31:TOP_LSB]);
        hit       = in_window && (int'(idx) < NUM_SLV);
        sel       = '0;
        if (hit) sel[idx] = 1'b1;
    end
endmodule

// File: rtl/apb_master.sv
// Core data-bus to APB bridge: latches one request, runs SETUP/ACCESS on the
// decoded slot (or a one-cycle MISS), and returns rdata with a ready pulse.
module apb_master
    import apb_pkg::*;
#(
    parameter int          NUM_SLV   = DEF_NUM_SLV,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          SLV_AW    = DEF_SLV_AW
) (
    input  logic          clk,
    input  logic          rst,
    // Handshake: transfer is sampled only in IDLE; every accepted transfer
    // gets exactly one ready pulse, and the requester holds off until then.
    input  logic          transfer,
    input  logic          write,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          ready,
    output logic          err,
    apb_master_if.master  apb,
    output apb_state_e    state_dbg
);
    apb_state_e         state_q, state_d;
    logic [NUM_SLV-1:0] dec_sel, psel_q;
    logic               dec_hit;
    logic [31:0]        paddr_q, pwdata_q, rdata_q;
    logic               pwrite_q, ready_q, err_q;
    logic [31:0]        sel_prdata;
    logic               sel_pready;

    apb_addr_decoder #(
        .NUM_SLV  (NUM_SLV),
        .BASE_ADDR(BASE_ADDR),
        .SLV_AW   (SLV_AW)
    ) u_dec (
        .addr(addr),
        .sel (dec_sel),
        .hit (dec_hit)
    );

    // Only the latched slot's PREADY/PRDATA are visible to the FSM.
    always_comb begin
        sel_prdata = '0;
        sel_pready = |(apb.PREADY & psel_q);
        for (int i = 0; i < NUM_SLV; i++) begin
            if (psel_q[i]) sel_prdata |= apb.PRDATA[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (transfer) state_d = dec_hit ? SETUP : MISS;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (sel_pready) state_d = IDLE;
            MISS:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        apb.PSEL    = '0;
        apb.PENABLE = 1'b0;
        case (state_q)
            SETUP:   apb.PSEL = psel_q;
            ACCESS: begin
                apb.PSEL    = psel_q;
                apb.PENABLE = 1'b1;
            end
            default: ;
        endcase
        apb.PADDR  = paddr_q;
        apb.PWDATA = pwdata_q;
        apb.PWRITE = pwrite_q;
    end

    // Request latch and completion registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            psel_q   <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (transfer) begin
                        paddr_q  <= addr;
                        pwdata_q <= wdata;
                        pwrite_q <= write;
                        psel_q   <= dec_sel;
                    end
                end
                ACCESS: begin
                    if (sel_pready) begin
                        ready_q <= 1'b1;
                        if (!pwrite_q) rdata_q <= sel_prdata;
                    end
                end
                MISS: begin
                    ready_q <= 1'b1;
                    err_q   <= 1'b1;
                    if (!pwrite_q) rdata_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign ready     = ready_q;
    assign err       = err_q;
    assign state_dbg = state_q;
endmodule
